// File: rtl/sdes_cbc_chain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sdes_cbc_chain
// Brief    : CBC chaining front/back end around a combinational S-DES core,
//            with a byte valid/ready input and a small ciphertext output FIFO.
// Revision : 1.0
// ============================================================================
module sdes_cbc_chain #(
  parameter int CORE_LAT   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [9:0] key_in,
  input  logic [7:0] iv_in,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic [7:0] core_pt,
  output logic [9:0] core_key,
  input  logic [7:0] core_ct,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = $clog2(CORE_LAT + 1);

  localparam logic [c_CNT_W-1:0] c_LAT      = c_CNT_W'(CORE_LAT);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
  localparam logic [c_PTR_W:0]   c_CNT_FULL = (c_PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [c_PTR_W:0]   c_CNT_INC  = (c_PTR_W + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t             r_state;
  logic [7:0]         r_chain;
  logic [9:0]         r_key;
  logic [7:0]         r_pt;
  logic               r_last;
  logic [c_CNT_W-1:0] r_cnt;

  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic [7:0]         r_mem_data [FIFO_DEPTH];
  logic               r_mem_last [FIFO_DEPTH];

  logic w_full;
  logic w_empty;
  logic w_accept;
  logic w_capture;
  logic w_pop;

  assign w_full    = (r_count == c_CNT_FULL);
  assign w_empty   = (r_count == '0);
  assign in_ready  = (r_state == ST_ARMED) && !w_full && !load;
  assign w_accept  = in_valid && in_ready;
  assign w_capture = (r_state == ST_WAIT) && (r_cnt == c_CNT_ONE);
  assign w_pop     = !w_empty && out_ready;

  assign core_pt   = r_pt;
  assign core_key  = r_key;
  assign out_valid = !w_empty;
  assign out_data  = w_empty ? 8'h00 : r_mem_data[r_rd_ptr];
  assign out_last  = w_empty ? 1'b0  : r_mem_last[r_rd_ptr];
  assign busy      = (r_state != ST_IDLE) || !w_empty;

  // Chaining FSM; load has priority over a byte offered in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_chain <= 8'h00;
      r_key   <= 10'h000;
      r_pt    <= 8'h00;
      r_last  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_key   <= key_in;
            r_chain <= iv_in;
            r_state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (load) begin
            r_key   <= key_in;
            r_chain <= iv_in;
          end else if (w_accept) begin
            r_pt    <= in_data ^ r_chain;
            r_last  <= in_last;
            r_cnt   <= c_LAT;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - c_CNT_ONE;
          if (r_cnt == c_CNT_ONE) begin
            r_chain <= core_ct;
            r_state <= r_last ? ST_IDLE : ST_ARMED;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Acceptance already guarantees a free slot, so the push is never gated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_capture) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_capture, w_pop})
        2'b10:   r_count <= r_count + c_CNT_INC;
        2'b01:   r_count <= r_count - c_CNT_INC;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_mem_data[r_wr_ptr] <= core_ct;
      r_mem_last[r_wr_ptr] <= r_last;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdes_cbc_chain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sdes_cbc_chain
// Brief    : Bench for sdes_cbc_chain with stub and full S-DES core models.
// Revision : 1.0
// ============================================================================
module tb_sdes_cbc_chain;

  localparam logic [1:0] c_S0 [16] = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0,
                                       2'd0, 2'd2, 2'd1, 2'd3, 2'd3, 2'd1, 2'd3, 2'd2};
  localparam logic [1:0] c_S1 [16] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3,
                                       2'd3, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, load, in_valid, in_ready, in_last, out_valid, out_ready, out_last, busy;
  logic [9:0] key_in, core_key;
  logic [7:0] iv_in, in_data, core_pt, core_ct, out_data;
  logic       load3, in_valid3, in_ready3, in_last3, out_valid3, out_ready3, out_last3, busy3;
  logic [9:0] key3_in, core_key3;
  logic [7:0] iv3_in, in_data3, core_pt3, core_ct3, out_data3;

  logic       use_sdes;
  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q [$];
  logic [7:0] m_chain;
  logic [9:0] m_key;

  function automatic logic [7:0] fk(input logic [7:0] x, input logic [7:0] sk);
    logic [3:0] r, s, p4;
    logic [7:0] ep;
    r  = x[3:0];
    ep = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]} ^ sk;
    s  = {c_S0[{ep[7], ep[4], ep[6], ep[5]}], c_S1[{ep[3], ep[0], ep[2], ep[1]}]};
    p4 = {s[2], s[0], s[1], s[3]};
    return {x[7:4] ^ p4, r};
  endfunction

  function automatic logic [7:0] sdes_enc(input logic [7:0] p, input logic [9:0] k);
    logic [9:0] t;
    logic [4:0] l, r;
    logic [7:0] k1, k2, x;
    t  = {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
    l  = {t[8:5], t[9]};
    r  = {t[3:0], t[4]};
    t  = {l, r};
    k1 = {t[4], t[7], t[3], t[6], t[2], t[5], t[0], t[1]};
    l  = {l[2:0], l[4:3]};
    r  = {r[2:0], r[4:3]};
    t  = {l, r};
    k2 = {t[4], t[7], t[3], t[6], t[2], t[5], t[0], t[1]};
    x  = {p[6], p[2], p[5], p[7], p[4], p[0], p[3], p[1]};
    x  = fk(x, k1);
    x  = {x[3:0], x[7:4]};
    x  = fk(x, k2);
    return {x[4], x[7], x[5], x[3], x[1], x[6], x[0], x[2]};
  endfunction

  function automatic logic [7:0] model_core(input logic [7:0] p);
    return use_sdes ? sdes_enc(p, m_key) : ~p;
  endfunction

  assign core_ct  = use_sdes ? sdes_enc(core_pt, core_key) : ~core_pt;
  assign core_ct3 = ~core_pt3;

  sdes_cbc_chain #(.CORE_LAT(1), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .load(load), .key_in(key_in), .iv_in(iv_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .core_pt(core_pt), .core_key(core_key), .core_ct(core_ct),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  sdes_cbc_chain #(.CORE_LAT(3), .FIFO_DEPTH(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .load(load3), .key_in(key3_in), .iv_in(iv3_in),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3), .in_last(in_last3),
    .core_pt(core_pt3), .core_key(core_key3), .core_ct(core_ct3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .out_last(out_last3), .busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every popped byte must match the oldest predicted ciphertext.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL out_unexpected observed=0x%0h expected=none", {out_data, out_last});
      end else begin
        e = exp_q.pop_front();
        check("out_byte", 32'({out_data, out_last}), 32'(e));
      end
    end
  end

  task automatic do_load(input logic [9:0] k, input logic [7:0] iv);
    load = 1'b1; key_in = k; iv_in = iv;
    @(posedge clk); #1;
    load = 1'b0;
    m_key = k; m_chain = iv;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    bit got;
    logic [7:0] ct;
    got = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = l;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("send_accept", 32'(got), 32'd1);
    if (got) begin
      ct = model_core(d ^ m_chain);
      m_chain = ct;
      exp_q.push_back({ct, l});
    end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 200) begin
      @(posedge clk);
      i++;
    end
    @(posedge clk); #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] b [6];
  logic [7:0] v, a3, b3, c1;
  logic [9:0] k3;
  bit         got3;

  initial begin
    rst_n = 1'b0; load = 1'b0; key_in = '0; iv_in = '0; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; out_ready = 1'b1; use_sdes = 1'b0; m_chain = '0; m_key = '0;
    load3 = 1'b0; key3_in = '0; iv3_in = '0; in_valid3 = 1'b0; in_data3 = '0;
    in_last3 = 1'b0; out_ready3 = 1'b1;

    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'({out_data, out_last}), 32'd0);
    check("rst_core", 32'({core_pt, core_key}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", 32'(in_ready), 32'd0);

    // Stub core, known vectors
    do_load(10'h155, 8'h00);
    send(8'h12, 1'b0);
    check("stub_pt0", 32'(core_pt), 32'h12);
    @(posedge clk); #1;
    check("stub_ct0", 32'({out_valid, out_data, out_last}), 32'({1'b1, 8'hED, 1'b0}));
    send(8'h34, 1'b1);
    check("stub_pt1", 32'(core_pt), 32'hD9);
    @(posedge clk); #1;
    check("stub_ct1", 32'({out_data, out_last}), 32'({8'h26, 1'b1}));
    check("stub_idle", 32'(in_ready), 32'd0);
    drain();
    check("stub_busy", 32'(busy), 32'd0);

    // Real S-DES known-answer vector
    use_sdes = 1'b1;
    do_load(10'b1010000010, 8'h00);
    check("kat_key", 32'(core_key), 32'h282);
    send(8'h97, 1'b1);
    @(posedge clk); #1;
    check("kat_ct", 32'({out_data, out_last}), 32'({8'h38, 1'b1}));
    drain();
    check("kat_busy", 32'(busy), 32'd0);

    // Backpressure with random data
    out_ready = 1'b0;
    do_load(10'($urandom), 8'($urandom));
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) send(b[i], 1'b0);
    @(posedge clk); #1;
    check("bp_head", 32'(out_data), 32'(exp_q[0][8:1]));
    in_valid = 1'b1; in_data = b[4];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_full_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    check("bp_head_hold", 32'({out_valid, out_data}), 32'({1'b1, exp_q[0][8:1]}));
    out_ready = 1'b1;
    send(b[4], 1'b0);
    send(b[5], 1'b1);
    drain();

    // load with in_valid in ARMED, then load during WAIT
    do_load(10'($urandom), 8'($urandom));
    v = 8'($urandom); a3 = 8'($urandom); k3 = 10'($urandom);
    load = 1'b1; key_in = k3; iv_in = v; in_valid = 1'b1; in_data = a3;
    @(negedge clk);
    check("ld_pri_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    load = 1'b0; m_key = k3; m_chain = v;
    check("ld_new_key", 32'(core_key), 32'(k3));
    send(a3, 1'b0);
    check("ld_new_iv", 32'(core_pt), 32'(a3 ^ v));
    load = 1'b1; key_in = ~k3; iv_in = ~v;
    @(posedge clk); #1;
    load = 1'b0;
    check("ld_wait_key", 32'(core_key), 32'(k3));
    send(8'($urandom), 1'b1);
    drain();

    // Asynchronous reset during WAIT with buffered output
    out_ready = 1'b0;
    do_load(10'($urandom), 8'($urandom));
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0);
    check("rs_buffered", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rs_out_valid", 32'({out_valid, out_data, out_last}), 32'd0);
    check("rs_core_pt", 32'(core_pt), 32'd0);
    check("rs_in_ready", 32'({in_ready, busy}), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rs_need_load", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rs_no_out", 32'(out_valid), 32'd0);

    // CORE_LAT=3 instance: hold time, capture edge, throughput
    v = 8'($urandom); a3 = 8'($urandom); b3 = 8'($urandom); k3 = 10'($urandom);
    load3 = 1'b1; iv3_in = v; key3_in = k3;
    @(posedge clk); #1;
    load3 = 1'b0;
    check("l3_key", 32'(core_key3), 32'(k3));
    in_valid3 = 1'b1; in_data3 = a3; in_last3 = 1'b0;
    got3 = 1'b0;
    for (int i = 0; i < 20 && !got3; i++) begin
      @(negedge clk);
      if (in_ready3) got3 = 1'b1;
      @(posedge clk); #1;
    end
    check("l3_accept", 32'(got3), 32'd1);
    in_data3 = b3; in_last3 = 1'b1;
    c1 = ~(a3 ^ v);
    check("l3_pt0", 32'(core_pt3), 32'(a3 ^ v));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("l3_pt_hold", 32'(core_pt3), 32'(a3 ^ v));
      check("l3_not_yet", 32'({out_valid3, in_ready3}), 32'd0);
    end
    @(posedge clk); #1;
    check("l3_capture", 32'({out_valid3, out_data3, out_last3}), 32'({1'b1, c1, 1'b0}));
    check("l3_rearmed", 32'({in_ready3, core_pt3}), 32'({1'b1, a3 ^ v}));
    @(posedge clk); #1;
    in_valid3 = 1'b0; in_last3 = 1'b0;
    check("l3_pt1", 32'(core_pt3), 32'(b3 ^ c1));
    repeat (2) @(posedge clk);
    #1;
    check("l3_empty", 32'(out_valid3), 32'd0);
    @(posedge clk); #1;
    check("l3_ct1", 32'({out_valid3, out_data3, out_last3}), 32'({1'b1, ~(b3 ^ c1), 1'b1}));
    @(posedge clk); #1;
    check("l3_done", 32'({busy3, in_ready3}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
